// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle, followed by a sign-fix cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             flush,
    output logic             resp_valid,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             negA_q, negA_d;
    logic             negB_q, negB_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             aSigned, bSigned, aNeg, bNeg;
    logic [WIDTH-1:0] aMag, bMag;
    logic             divZero, divOverflow;
    logic [WIDTH-1:0] specialRes;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic             divFits;
    logic [WIDTH-1:0] divDiff;
    logic [2*WIDTH-1:0] prodRaw, prodFix;
    logic [WIDTH-1:0] quoFix, remFix, fixRes;

    // Request decode: which operands are signed and their magnitudes
    always_comb begin
        aSigned = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        bSigned = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        aNeg    = aSigned & rs1[WIDTH-1];
        bNeg    = bSigned & rs2[WIDTH-1];
        aMag    = aNeg ? -rs1 : rs1;
        bMag    = bNeg ? -rs2 : rs2;
        divZero     = (rs2 == '0);
        divOverflow = ~funct3[0] & (rs1 == MIN_NEG) & (rs2 == '1);
        if (divZero) begin
            specialRes = funct3[1] ? rs1 : '1;
        end else begin
            specialRes = funct3[1] ? '0 : rs1;
        end
    end

    // Datapath step and sign correction; the comparison uses the full shifted
    // value so only the low WIDTH bits of the difference are ever needed
    always_comb begin
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        divShift = {hi_q, lo_q[WIDTH-1]};
        divFits  = (divShift >= {1'b0, b_q});
        divDiff  = divShift[WIDTH-1:0] - b_q;
        prodRaw  = {hi_q, lo_q};
        prodFix  = (negA_q ^ negB_q) ? -prodRaw : prodRaw;
        quoFix   = (negA_q ^ negB_q) ? -lo_q : lo_q;
        remFix   = negA_q ? -hi_q : hi_q;
        case (op_q)
            3'd0:          fixRes = prodFix[WIDTH-1:0];
            3'd4, 3'd5:    fixRes = quoFix;
            3'd6, 3'd7:    fixRes = remFix;
            default:       fixRes = prodFix[2*WIDTH-1:WIDTH];
        endcase
    end

    // Next-state logic; flush overrides every state and never touches result
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        negA_d   = negA_q;
        negB_d   = negB_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_d   = funct3;
                        negA_d = aNeg;
                        negB_d = bNeg;
                        cnt_d  = '0;
                        hi_d   = '0;
                        if (funct3[2]) begin
                            lo_d = aMag;
                            b_d  = bMag;
                        end else begin
                            lo_d = bMag;
                            b_d  = aMag;
                        end
                        if (funct3[2] && (divZero || divOverflow)) begin
                            result_d = specialRes;
                            state_d  = DONE;
                        end else begin
                            state_d  = CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        hi_d = divFits ? divDiff : divShift[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], divFits};
                    end else begin
                        hi_d = mulSum[WIDTH:1];
                        lo_d = {mulSum[0], lo_q[WIDTH-1:1]};
                    end
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                FIX: begin
                    result_d = fixRes;
                    state_d  = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            negA_q   <= 1'b0;
            negB_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            negA_q   <= negA_d;
            negB_q   <= negB_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign result     = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector and golden-model bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        resp_valid;
    logic [31:0] result;

    int checks;
    int failures;
    int cycleCount;
    int acceptCycle;
    logic [31:0] lastResult;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .flush      (flush),
        .resp_valid (resp_valid),
        .result     (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Golden model built on native 64-bit and C-style integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [63:0] pu;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
        return ua[31:0] ^ ub[31:0];
    endfunction

    function automatic int modelLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0)) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request from a negedge, then sample each later negedge until resp_valid
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] got, output int lat, output bit timedOut,
                                 output bit unstable, output bit longPulse);
        int g;
        g = 0;
        while (!req_ready && g < 100) begin
            @(negedge clock);
            g++;
        end
        req_valid = 1'b1;
        funct3    = f3;
        rs1       = a;
        rs2       = b;
        @(posedge clock);
        #1;
        acceptCycle = cycleCount;
        req_valid   = 1'b0;
        funct3      = 3'($urandom);
        rs1         = $urandom;
        rs2         = $urandom;
        lat      = 0;
        timedOut = 1'b1;
        unstable = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            lat++;
            if (resp_valid) begin
                timedOut = 1'b0;
                break;
            end
            if (result !== lastResult) unstable = 1'b1;
        end
        got = result;
        @(negedge clock);
        longPulse = resp_valid;
    endtask

    task automatic runOp(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int expLat);
        logic [31:0] got;
        int lat;
        bit timedOut, unstable, longPulse;
        applyStimulus(f3, a, b, got, lat, timedOut, unstable, longPulse);
        if (timedOut) begin
            checkOutput({name, " response timeout"}, 32'd1, 32'd0);
        end else begin
            checkOutput({name, " result"}, got, exp);
            checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
        end
        checkOutput({name, " result held before response"}, {31'b0, unstable}, 32'd0);
        checkOutput({name, " single-cycle pulse"}, {31'b0, longPulse}, 32'd0);
        lastResult = exp;
    endtask

    initial begin
        int firstAccept;
        bit seen;
        logic [2:0] f3;
        logic [31:0] a, b;

        checks     = 0;
        failures   = 0;
        cycleCount = 0;
        lastResult = 32'h0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        funct3     = 3'd0;
        rs1        = 32'h0;
        rs2        = 32'h0;
        flush      = 1'b0;

        vecs.push_back('{"MUL -1*3",        3'd0, 32'hFFFF_FFFF, 32'h3,         32'hFFFF_FFFD, 34});
        vecs.push_back('{"MULH -1*3",       3'd1, 32'hFFFF_FFFF, 32'h3,         32'hFFFF_FFFF, 34});
        vecs.push_back('{"MULHU -1*3",      3'd3, 32'hFFFF_FFFF, 32'h3,         32'h0000_0002, 34});
        vecs.push_back('{"MULHSU -1*3",     3'd2, 32'hFFFF_FFFF, 32'h3,         32'hFFFF_FFFF, 34});
        vecs.push_back('{"MUL small",       3'd0, 32'h1234_5678, 32'h10,        32'h2345_6780, 34});
        vecs.push_back('{"MULH min*min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
        vecs.push_back('{"MULHSU min*max",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34});
        vecs.push_back('{"DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 34});
        vecs.push_back('{"REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{"DIVU -7/2",       3'd5, 32'hFFFF_FFF9, 32'h2,         32'h7FFF_FFFC, 34});
        vecs.push_back('{"REMU -7/2",       3'd7, 32'hFFFF_FFF9, 32'h2,         32'h0000_0001, 34});
        vecs.push_back('{"DIV -7/-2",       3'd4, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 34});
        vecs.push_back('{"REM -7/-2",       3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34});
        vecs.push_back('{"DIV 7/-2",        3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34});
        vecs.push_back('{"REM 7/-2",        3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34});
        vecs.push_back('{"DIVU min/max",    3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34});
        vecs.push_back('{"DIV 5/0",         3'd4, 32'h0000_0005, 32'h0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{"REMU 5/0",        3'd7, 32'h0000_0005, 32'h0,         32'h0000_0005, 1});
        vecs.push_back('{"DIVU 5/0",        3'd5, 32'h0000_0005, 32'h0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{"REM 5/0",         3'd6, 32'h0000_0005, 32'h0,         32'h0000_0005, 1});
        vecs.push_back('{"DIV overflow",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{"REM overflow",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});

        repeat (3) @(negedge clock);
        checkOutput("reset req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("reset result", result, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            runOp(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        $display("[TB] back-to-back throughput");
        runOp("b2b MUL", 3'd0, 32'd6, 32'd7, 32'd42, 34);
        firstAccept = acceptCycle;
        runOp("b2b MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        checkOutput("b2b accept spacing", 32'(acceptCycle - firstAccept), 32'd35);

        $display("[TB] flush and busy request");
        req_valid = 1'b1;
        funct3    = 3'd5;
        rs1       = 32'd100;
        rs2       = 32'd7;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(negedge clock);
            if (i == 4) begin
                req_valid = 1'b1;
                funct3    = 3'd4;
                rs2       = 32'h0;
                checkOutput("busy req_ready", {31'b0, req_ready}, 32'd0);
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        checkOutput("flush to idle", {31'b0, req_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (resp_valid) seen = 1'b1;
        end
        checkOutput("flush no response", {31'b0, seen}, 32'd0);
        checkOutput("flush result unchanged", result, lastResult);

        $display("[TB] flush with request in idle");
        req_valid = 1'b1;
        flush     = 1'b1;
        funct3    = 3'd4;
        rs1       = 32'd9;
        rs2       = 32'd0;
        @(negedge clock);
        req_valid = 1'b0;
        flush     = 1'b0;
        checkOutput("flush blocks accept ready", {31'b0, req_ready}, 32'd1);
        checkOutput("flush blocks accept resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clock);
        checkOutput("flush blocks accept result", result, lastResult);

        $display("[TB] reset mid-calculation");
        req_valid = 1'b1;
        funct3    = 3'd0;
        rs1       = 32'd1234;
        rs2       = 32'd5678;
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid reset req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("mid reset resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("mid reset result", result, 32'h0);
        @(negedge clock);
        reset_n    = 1'b1;
        lastResult = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (resp_valid) seen = 1'b1;
        end
        checkOutput("no stale response after reset", {31'b0, seen}, 32'd0);
        checkOutput("result cleared after reset", result, 32'h0);

        $display("[TB] random operations against golden model");
        for (int n = 0; n < 300; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pickOperand();
            b  = pickOperand();
            runOp($sformatf("rand%0d f3=%0d a=%08h b=%08h", n, f3, a, b), f3, a, b,
                  model(f3, a, b), modelLatency(f3, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
